// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: packs big-endian words, writes them at
// BASE_ADDR, +4, ... and holds the CPU in reset while loading. Option: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256,
    parameter int          ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        st_idle,
        st_len_hi,
        st_len_lo,
        st_data,
        st_cksum,
        st_done
    } state_t;

    localparam logic [ADDR_W-1:0] base_a = ADDR_W'(BASE_ADDR);
    localparam logic [31:0]       max_w  = 32'(MAX_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t st_tail = st_cksum;
`else
    localparam state_t st_tail = st_done;
`endif

    state_t            state, state_nx;
    logic [15:0]       len_q;
    logic [15:0]       word_idx;
    logic [1:0]        byte_cnt;
    logic [23:0]       word_sr;
    logic [ADDR_W-1:0] wr_addr;
    logic              xfer;
    logic              last_byte;
    logic [15:0]       len_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        cksum;
`endif

    assign xfer      = in_valid && in_ready;
    assign len_full  = {len_q[15:8], in_data};
    assign last_byte = (byte_cnt == 2'd3) && (word_idx == len_q - 16'd1);
    assign cpu_reset = busy;

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state)
            st_idle: begin
                busy = 1'b0;
                if (start) state_nx = st_len_hi;
            end
            st_len_hi: begin
                in_ready = 1'b1;
                if (xfer) state_nx = st_len_lo;
            end
            st_len_lo: begin
                in_ready = 1'b1;
                if (xfer) state_nx = (len_full != 16'd0) ? st_data : st_tail;
            end
            st_data: begin
                in_ready = 1'b1;
                if (xfer && last_byte) state_nx = st_tail;
            end
            st_cksum: begin
                in_ready = 1'b1;
                if (xfer) state_nx = st_done;
            end
            st_done: begin
                done     = 1'b1;
                state_nx = st_idle;
            end
            default: state_nx = st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= st_idle;
            len_q     <= '0;
            word_idx  <= '0;
            byte_cnt  <= '0;
            word_sr   <= '0;
            wr_addr   <= base_a;
            mem_we    <= 1'b0;
            mem_addr  <= base_a;
            mem_wdata <= '0;
            error     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            cksum     <= '0;
`endif
        end else begin
            state  <= state_nx;
            mem_we <= 1'b0;
            if (state == st_idle && start) begin
                error    <= 1'b0;
                word_idx <= '0;
                byte_cnt <= '0;
                wr_addr  <= base_a;
`ifdef IMEM_LOADER_CHECKSUM_EN
                cksum    <= '0;
`endif
            end
            if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                cksum <= cksum ^ in_data;
`endif
                case (state)
                    st_len_hi: len_q[15:8] <= in_data;
                    st_len_lo: begin
                        len_q[7:0] <= in_data;
                        if ({16'd0, len_full} > max_w) error <= 1'b1;
                    end
                    st_data: begin
                        byte_cnt <= byte_cnt + 2'd1;
                        word_sr  <= {word_sr[15:0], in_data};
                        if (byte_cnt == 2'd3) begin
                            word_idx <= word_idx + 16'd1;
                            wr_addr  <= wr_addr + ADDR_W'(4);
                            // Words past the memory depth are consumed but never written.
                            if ({16'd0, word_idx} < max_w) begin
                                mem_we    <= 1'b1;
                                mem_addr  <= wr_addr;
                                mem_wdata <= {word_sr, in_data};
                            end
                        end
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    st_cksum: if ((cksum ^ in_data) != 8'h00) error <= 1'b1;
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a byte-list reference model predicts writes and
// error status; a monitor compares every mem_we and done pulse against the queues.
module tb_imem_loader;

    localparam int          TB_MAX  = 2;
    localparam logic [31:0] TB_BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    imem_loader #(
        .BASE_ADDR(TB_BASE),
        .MAX_WORDS(TB_MAX),
        .ADDR_W   (32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wq[$];
    bit          err_q[$];
    logic [7:0]  img[$];
    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: what a loader must do with the byte list in img.
    task automatic ref_expect(output bit exp_err);
        int   n;
        wr_t  w;
        logic [7:0] x;
        n = {img[0], img[1]};
        for (int i = 0; i < n; i++) begin
            w.addr = TB_BASE + 32'(4 * i);
            w.data = {img[2+4*i], img[3+4*i], img[4+4*i], img[5+4*i]};
            if (i < TB_MAX) wq.push_back(w);
        end
        exp_err = (n > TB_MAX);
        x = 8'h00;
        foreach (img[i]) x ^= img[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (x != 8'h00) exp_err = 1'b1;
`endif
        err_q.push_back(exp_err);
    endtask

    task automatic add_cksum(input logic [7:0] tweak);
        logic [7:0] x;
        x = tweak;
        foreach (img[i]) x ^= img[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
        img.push_back(x);
`endif
    endtask

    task automatic mk_image(input int n, input logic [7:0] tweak);
        img = {};
        img.push_back(8'(n >> 8));
        img.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
        add_cksum(tweak);
    endtask

    // Called at a negedge; returns at the negedge after the byte was consumed.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            chk_cnt++;
            $display("FAIL send_timeout: in_ready stuck low, byte %h", b);
        end
        @(negedge clk);
    endtask

    task automatic run_image(input int gap, input bit start_mid);
        bit exp_err;
        int prev;
        int n;
        int t;
        n = {img[0], img[1]};
        prev = done_cnt;
        ref_expect(exp_err);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("cpu_reset_after_start", cpu_reset, 1);
        check("error_cleared", error, 0);
        foreach (img[i]) begin
            if (start_mid && i == 4) start = 1'b1;
            send_byte(img[i]);
            start = 1'b0;
            if (i == 1) begin
                check("error_after_len", error, 32'(n > TB_MAX));
`ifndef IMEM_LOADER_CHECKSUM_EN
                if (n == 0) check("done_after_len0", done, 1);
`endif
            end
            if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        t = 0;
        while (done_cnt == prev && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt == prev) begin
            chk_cnt++;
            $display("FAIL done_timeout: done_cnt %0d expected %0d", done_cnt, prev + 1);
        end
        t = 0;
        while (done && t < 5) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check("done_once", done_cnt, prev + 1);
        check("busy_idle", busy, 0);
        check("cpu_reset_idle", cpu_reset, 0);
        check("error_sticky", error, 32'(exp_err));
        check("writes_drained", wq.size(), 0);
        wq = {};
        err_q = {};
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (mem_we) begin
                last_addr <= mem_addr;
                last_data <= mem_wdata;
                if (wq.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL unexpected_write: addr %h data %h, expected no write", mem_addr, mem_wdata);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    check("wr_addr", mem_addr, e.addr);
                    check("wr_data", mem_wdata, e.data);
                end
            end
            if (done) begin
                done_cnt++;
                check("done_hold", {29'd0, busy, cpu_reset, in_ready}, 32'b110);
                if (err_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL unexpected_done: error %b, expected no done", error);
                end else begin
                    check("done_error", error, 32'(err_q.pop_front()));
                end
            end
        end
    end

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, TB_BASE);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_busy", {30'd0, busy, cpu_reset}, 0);
        check("rst_done_error", {30'd0, done, error}, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Abort mid-load: 5 bytes consumed, 6th on the bus when reset hits.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        img = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05};
        for (int i = 0; i < 5; i++) send_byte(img[i]);
        in_valid = 1'b1;
        in_data  = img[5];
        #1 reset = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 0);
        check("abort_mem_we", mem_we, 0);
        check("abort_busy", {30'd0, busy, cpu_reset}, 0);
        check("abort_mem_addr", mem_addr, TB_BASE);
        check("abort_mem_wdata", mem_wdata, 0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_mem_we_held", mem_we, 0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_idle", busy, 0);

        img = {8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        add_cksum(8'h00);
        run_image(0, 1'b0);
        check("one_word_data", last_data, 32'hDEADBEEF);

        img = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
        add_cksum(8'h00);
        run_image(0, 1'b0);
        check("t2_last_addr", last_addr, 32'h4);
        check("t2_last_data", last_data, 32'hAC080000);

        img = {8'h00, 8'h00};
        add_cksum(8'h00);
        run_image(0, 1'b0);

        img = {8'h00, 8'h03};
        for (int i = 0; i < 12; i++) img.push_back(8'(i + 1));
        add_cksum(8'h00);
        run_image(0, 1'b0);
        check("ovf_last_addr", last_addr, 32'h4);

        img = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
        add_cksum(8'h00);
        run_image(1, 1'b1);
        check("t5_last_data", last_data, 32'hAC080000);

`ifdef IMEM_LOADER_CHECKSUM_EN
        img = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00, 8'h8B};
        run_image(0, 1'b0);
        img = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00, 8'h8C};
        run_image(0, 1'b0);
`endif

        for (int k = 0; k < 20; k++) begin
            mk_image($urandom_range(0, 4), ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
            run_image(2, $urandom_range(0, 1) == 1);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
